// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite subordinate serving single-beat transfers from an internal word SRAM,
// with programmable wait states, byte-lane strobes and the two-cycle ERROR response.
module ahb_sram_subordinate #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          MEM_WORDS   = 1024,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic [3:0]  HWSTRB,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic [2:0]  dbg_state_o
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;
    localparam logic [3:0]  WS_INIT   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            write_q;
    logic [2:0]      size_q;
    logic [1:0]      lo_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     mem [MEM_WORDS];

    logic [32:0]     off;
    logic            misalign, addr_err, accept, capture;
    logic [3:0]      size_mask, wmask;
    logic            unused_ok;

    // 33-bit offset so addresses near 2^32 cannot wrap back into range.
    assign off      = {1'b0, HADDR} - {1'b0, BASE_ADDR};
    assign misalign = ((HSIZE == 3'd1) && HADDR[0]) || ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
    assign addr_err = (HSIZE > 3'd2) || misalign || (HADDR < BASE_ADDR) || (off >= MEM_BYTES);
    assign accept   = HSEL && HREADY && HTRANS[1];
    assign unused_ok = ^{HBURST, HTRANS[0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (accept) begin
                    capture = 1'b1;
                    cnt_d   = WS_INIT;
                    if (addr_err)             state_d = ST_ERR1;
                    else if (WAIT_STATES > 0) state_d = ST_WAIT;
                    else                      state_d = ST_DATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) state_d = ST_DATA;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
            lo_q    <= 2'd0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                write_q <= HWRITE;
                size_q  <= HSIZE;
                lo_q    <= HADDR[1:0];
                idx_q   <= off[AW+1:2];
            end
        end
    end

    always_comb begin
        case (size_q)
            3'd0:    size_mask = 4'b0001 << lo_q;
            3'd1:    size_mask = 4'b0011 << lo_q;
            default: size_mask = 4'b1111;
        endcase
        wmask = HWSTRB & size_mask;
    end

    // The array is never reset; a reset edge suppresses an in-flight commit.
    always_ff @(posedge clk) begin
        if (!reset && (state_q == ST_DATA) && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

    assign HREADYOUT   = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
    assign HRESP       = (state_q == ST_ERR1) || (state_q == ST_ERR2);
    assign HRDATA      = ((state_q == ST_DATA) && !write_q) ? mem[idx_q] : 32'd0;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// Directed bench: one zero-wait and one three-wait subordinate on a shared address/data bus.
module tb_ahb_sram_subordinate;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          WORDS = 64;
  localparam logic [1:0]  T_IDLE = 2'b00;
  localparam logic [1:0]  T_NSEQ = 2'b10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hsel0 = 1'b0, hsel3 = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = T_IDLE;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = '0;
  logic [31:0] hwdata = '0;
  logic [3:0]  hwstrb = '0;

  logic        rdy0, rsp0, rdy3, rsp3;
  logic [31:0] rdat0, rdat3;
  logic [2:0]  dbg0, dbg3;
  logic        sel_ws3 = 1'b0;
  logic        rdy, rsp;
  logic [31:0] rdat;
  logic [2:0]  dbg;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ahb_sram_subordinate #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(3'b000), .HWDATA(hwdata), .HWSTRB(hwstrb), .HREADY(rdy0),
    .HREADYOUT(rdy0), .HRESP(rsp0), .HRDATA(rdat0), .dbg_state_o(dbg0)
  );

  ahb_sram_subordinate #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .reset(reset), .HSEL(hsel3), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(3'b000), .HWDATA(hwdata), .HWSTRB(hwstrb), .HREADY(rdy3),
    .HREADYOUT(rdy3), .HRESP(rsp3), .HRDATA(rdat3), .dbg_state_o(dbg3)
  );

  assign rdy  = sel_ws3 ? rdy3  : rdy0;
  assign rsp  = sel_ws3 ? rsp3  : rsp0;
  assign rdat = sel_ws3 ? rdat3 : rdat0;
  assign dbg  = sel_ws3 ? dbg3  : dbg0;

  task automatic check32(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Drive one bus cycle just after the rising edge, then settle to the falling edge.
  task automatic cyc(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                     input logic wr, input logic [2:0] size, input logic [31:0] wd,
                     input logic [3:0] strb, input logic rst = 1'b0);
    @(posedge clk);
    #1;
    reset  = rst;
    hsel0  = sel & ~sel_ws3;
    hsel3  = sel & sel_ws3;
    htrans = trans;
    haddr  = addr;
    hwrite = wr;
    hsize  = size;
    hwdata = wd;
    hwstrb = strb;
    @(negedge clk);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    int n;
    n = 0;
    cyc(1'b1, T_NSEQ, addr, 1'b1, 3'd2, 32'd0, 4'h0);
    cyc(1'b0, T_IDLE, 32'd0, 1'b0, 3'd0, data, 4'hF);
    while (!rdy && n < 20) begin
      cyc(1'b0, T_IDLE, 32'd0, 1'b0, 3'd0, data, 4'hF);
      n++;
    end
    check32("wr_done", {31'd0, rdy}, 32'd1);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    int n;
    n = 0;
    cyc(1'b1, T_NSEQ, addr, 1'b0, 3'd2, 32'd0, 4'h0);
    cyc(1'b0, T_IDLE, 32'd0, 1'b0, 3'd0, 32'd0, 4'h0);
    while (!rdy && n < 20) begin
      cyc(1'b0, T_IDLE, 32'd0, 1'b0, 3'd0, 32'd0, 4'h0);
      n++;
    end
    check32({tag, "_rdy"}, {31'd0, rdy}, 32'd1);
    check32(tag, rdat, exp);
  endtask

  task automatic err_beat(input string tag, input logic [31:0] addr, input logic [2:0] size);
    cyc(1'b1, T_NSEQ, addr, 1'b1, size, 32'd0, 4'h0);
    cyc(1'b0, T_IDLE, 32'd0, 1'b0, 3'd0, 32'hFFFF_FFFF, 4'hF);
    check32({tag, "_e1"}, {30'd0, rdy, rsp}, 32'b01);
    cyc(1'b0, T_IDLE, 32'd0, 1'b0, 3'd0, 32'hFFFF_FFFF, 4'hF);
    check32({tag, "_e2"}, {30'd0, rdy, rsp}, 32'b11);
  endtask

  initial begin
    int data_cycles;
    int wait_lows;

    // Reset
    cyc(1'b0, T_IDLE, 32'd0, 1'b0, 3'd0, 32'd0, 4'h0, 1'b1);
    cyc(1'b0, T_IDLE, 32'd0, 1'b0, 3'd0, 32'd0, 4'h0, 1'b1);
    cyc(1'b0, T_IDLE, 32'd0, 1'b0, 3'd0, 32'd0, 4'h0);
    check32("rst_dut0", {rdy0, rsp0, 27'd0, dbg0}, {1'b1, 1'b0, 30'd0});
    check32("rst_rdata0", rdat0, 32'd0);
    check32("rst_dut3", {rdy3, rsp3, 27'd0, dbg3}, {1'b1, 1'b0, 30'd0});
    check32("rst_rdata3", rdat3, 32'd0);

    // Word write then pipelined read of the same word
    sel_ws3 = 1'b0;
    cyc(1'b1, T_NSEQ, BASE + 32'h10, 1'b1, 3'd2, 32'd0, 4'h0);
    cyc(1'b1, T_NSEQ, BASE + 32'h10, 1'b0, 3'd2, 32'hDEAD_BEEF, 4'hF);
    check32("t1_wr_phase", {30'd0, rdy, rsp}, 32'b10);
    cyc(1'b0, T_IDLE, 32'd0, 1'b0, 3'd0, 32'd0, 4'h0);
    check32("t1_rd_phase", {30'd0, rdy, rsp}, 32'b10);
    check32("t1_rdata", rdat, 32'hDEAD_BEEF);
    cyc(1'b0, T_IDLE, 32'd0, 1'b0, 3'd0, 32'd0, 4'h0);
    check32("t1_rdata_idle", rdat, 32'd0);

    // 16 writes + 16 reads back-to-back: 33 cycles, 32 data phases
    data_cycles = 0;
    for (int c = 0; c < 33; c++) begin
      int d;
      d = c - 1;
      cyc(c < 32, (c < 32) ? T_NSEQ : T_IDLE, BASE + 32'(4 * (c % 16)), c < 16, 3'd2,
          (d >= 0 && d < 16) ? 32'(d) : 32'd0, 4'hF);
      check32("burst_rdy", {31'd0, rdy}, 32'd1);
      if (dbg == 3'd2) data_cycles++;
      if (d >= 16) check32("burst_rdata", rdat, 32'(d - 16));
    end
    check32("burst_beats", 32'(data_cycles), 32'd32);

    // Byte strobes masked by size and lane
    do_write(BASE + 32'h20, 32'h1122_3344);
    cyc(1'b1, T_NSEQ, BASE + 32'h22, 1'b1, 3'd0, 32'd0, 4'h0);
    cyc(1'b0, T_IDLE, 32'd0, 1'b0, 3'd0, 32'h00AA_0000, 4'hF);
    do_read("byte_lane", BASE + 32'h20, 32'h11AA_3344);

    // Error responses leave memory untouched
    do_write(BASE + 32'h00, 32'hA0A0_A0A0);
    do_write(BASE + 32'h30, 32'hA1A1_A1A1);
    do_write(BASE + 32'hFC, 32'hA2A2_A2A2);
    err_beat("err_size3", BASE + 32'h30, 3'd3);
    err_beat("err_misal", BASE + 32'h32, 3'd2);
    err_beat("err_top", BASE + 32'(WORDS * 4), 3'd2);
    err_beat("err_below", BASE - 32'd4, 3'd2);
    do_read("err_mem0", BASE + 32'h00, 32'hA0A0_A0A0);
    do_read("err_mem30", BASE + 32'h30, 32'hA1A1_A1A1);
    do_read("err_memfc", BASE + 32'hFC, 32'hA2A2_A2A2);

    // Reset during a write data phase must not commit
    do_write(BASE + 32'h50, 32'h0BAD_F00D);
    cyc(1'b1, T_NSEQ, BASE + 32'h50, 1'b1, 3'd2, 32'd0, 4'h0);
    cyc(1'b0, T_IDLE, 32'd0, 1'b0, 3'd0, 32'hFFFF_FFFF, 4'hF, 1'b1);
    cyc(1'b0, T_IDLE, 32'd0, 1'b0, 3'd0, 32'd0, 4'h0);
    check32("rstdata_out", {rdy, rsp, 27'd0, dbg}, {1'b1, 1'b0, 30'd0});
    do_read("rstdata_mem", BASE + 32'h50, 32'h0BAD_F00D);

    // Three wait states: HREADYOUT low for exactly 3 cycles, data on the 4th
    sel_ws3 = 1'b1;
    do_write(BASE + 32'h40, 32'hCAFE_F00D);
    cyc(1'b1, T_NSEQ, BASE + 32'h40, 1'b0, 3'd2, 32'd0, 4'h0);
    wait_lows = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, T_IDLE, 32'd0, 1'b0, 3'd0, 32'd0, 4'h0);
      if (!rdy) wait_lows++;
      check32("ws3_rdata_wait", rdat, 32'd0);
    end
    check32("ws3_low_cycles", 32'(wait_lows), 32'd3);
    cyc(1'b0, T_IDLE, 32'd0, 1'b0, 3'd0, 32'd0, 4'h0);
    check32("ws3_data_rdy", {30'd0, rdy, rsp}, 32'b10);
    check32("ws3_rdata", rdat, 32'hCAFE_F00D);

    // Reset during WAIT of a write
    do_write(BASE + 32'h44, 32'h1234_5678);
    cyc(1'b1, T_NSEQ, BASE + 32'h44, 1'b1, 3'd2, 32'd0, 4'h0);
    cyc(1'b0, T_IDLE, 32'd0, 1'b0, 3'd0, 32'hFFFF_FFFF, 4'hF);
    check32("rstwait_low", {31'd0, rdy}, 32'd0);
    cyc(1'b0, T_IDLE, 32'd0, 1'b0, 3'd0, 32'hFFFF_FFFF, 4'hF, 1'b1);
    cyc(1'b0, T_IDLE, 32'd0, 1'b0, 3'd0, 32'd0, 4'h0);
    check32("rstwait_out", {rdy, rsp, 27'd0, dbg}, {1'b1, 1'b0, 30'd0});
    do_read("rstwait_mem", BASE + 32'h44, 32'h1234_5678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
